interrupt_injector: RTL and testbench
=====================================

// Module: interrupt_injector
// PURPOSE
//  Request side of the NMI/IRQ handshake. Synchronizes raw nNMI/nIRQ pins and edge-detects NMI into
//  nmiGenerated. At an instruction boundary it grants the highest-priority request, pulses
//  interruptAcknowleged, then drives the fixed-length interrupt push/vector sequence. nmiRunningFF
//  consumes nmiGenerated/interruptAcknowleged and returns nmiRunning; sits beside the decoder.
// PARAMETERS
//  SYNC_STAGES    2      synchronizer depth on nNMI and nIRQ (>=2)
//  INJECT_CYCLES  7      cycles in the injected sequence (>=2, <=8)
//  NMI_VECTOR_LO  8'hFA  low byte of NMI vector address
//  IRQ_VECTOR_LO  8'hFE  low byte of IRQ/BRK vector address
// PORTS
//  clk                    in   1  system clock, rising edge
//  nrst                   in   1  async active-low reset
//  enableFFs              in   1  global step enable; FSM/counter/nmiGenerated clear only when 1
//  nNMI                   in   1  raw NMI pin, active-low, asynchronous
//  nIRQ                   in   1  raw IRQ pin, active-low level, asynchronous
//  processStatusRegIFlag  in   1  P.I; 1 masks IRQ
//  nmiRunning             in   1  from nmiRunningFF; 1 blocks new NMI grants
//  instructionBoundary    in   1  1 in the cycle the next opcode would be fetched
//  synchronizedNMI        out  1  synchronized NMI level, active-high (= ~last nNMI stage)
//  nmiGenerated           out  1  latched NMI edge awaiting service
//  interruptAcknowleged   out  1  1-cycle grant pulse (combinational)
//  injectInterrupt        out  1  1 while in SEQ; decoder substitutes forced BRK opcode
//  serviceIsNMI           out  1  grant type of current/last sequence
//  sequenceStep           out  3  step 0..INJECT_CYCLES-1 within SEQ; 0 in IDLE
//  vectorAddrLow          out  8  NMI_VECTOR_LO if serviceIsNMI else IRQ_VECTOR_LO
// BEHAVIOUR
//  Reset: sync flops and edge-history flop = 1 (deasserted); state IDLE; nmiGenerated,
//   serviceIsNMI, sequenceStep = 0 -> all outputs 0, vectorAddrLow = IRQ_VECTOR_LO.
//   Reset mid-SEQ aborts immediately to IDLE, no pulse.
//  Synchronizers and edge detector run every clk regardless of enableFFs; edges never lost.
//  NMI edge: synced nNMI 1 (prev) -> 0 (now). Pin low at reset release: no edge until high, then low.
//   Latency pin fall -> nmiGenerated = 1: SYNC_STAGES+1 clk edges.
//  nmiGenerated: set on edge; cleared on clk edge where interruptAcknowleged & grant is NMI;
//   edge coincident with that clear wins (stays 1). Held indefinitely otherwise.
//  nmiReq = nmiGenerated & ~nmiRunning;  irqReq = ~nIRQ_sync & ~processStatusRegIFlag (level, unlatched).
//  interruptAcknowleged = IDLE & enableFFs & instructionBoundary & (nmiReq | irqReq).
//  FSM (advances only when enableFFs = 1; holds otherwise):
//   IDLE: on ack -> SEQ, sequenceStep <= 0, serviceIsNMI <= nmiReq (NMI beats IRQ).
//   SEQ : injectInterrupt = 1; sequenceStep increments per enabled cycle;
//         at step INJECT_CYCLES-1 -> IDLE, step <= 0. No ack pulses while in SEQ.
//  IRQ released or I set after grant: sequence still completes. NMI edge during IRQ SEQ: latched,
//   granted at next boundary after return to IDLE (no hijack).
//  vectorAddrLow stable for whole SEQ; serviceIsNMI holds its value in IDLE.
//  instructionBoundary ignored outside IDLE. No arithmetic beyond 3-bit step counter (no wrap).
// TESTING
//  1 nrst pulse with nNMI=0 held, then nNMI 0->1->0 -> nmiGenerated=0 until high-to-low
//    seen; rises SYNC_STAGES+1 clks after the fall.
//  2 NMI edge, boundary=1, nmiRunning=0 -> 1-clk ack, serviceIsNMI=1, vectorAddrLow=8'hFA,
//    injectInterrupt=1 for 7 clks, steps 0..6, nmiGenerated=0 after ack.
//  3 nIRQ=0, I=0, boundary=1 -> ack, vectorAddrLow=8'hFE; same with I=1 -> no ack for 20 clks.
//  4 NMI edge and IRQ both pending at same boundary -> NMI granted first; IRQ granted at next
//    boundary after SEQ ends (7 clks later).
//  5 enableFFs toggled 1,0,1,0 during SEQ -> step advances only on enable=1 (14 clks
//    total); NMI edge during enable=0 still sets nmiGenerated.
//  6 nmiRunning=1 with nmiGenerated=1 -> no ack; drop nmiRunning -> ack at next boundary.
//    nrst at step 3 -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/interrupt_injector.sv
`default_nettype none
// ------------------------------------------------------------------------
// interrupt_injector: NMI/IRQ pin sync, priority grant, forced-BRK sequencer
// Rev 1.0
// ------------------------------------------------------------------------
module interrupt_injector #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         INJECT_CYCLES = 7,
  parameter logic [7:0] NMI_VECTOR_LO = 8'hFA,
  parameter logic [7:0] IRQ_VECTOR_LO = 8'hFE
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enableFFs,
  input  logic       nNMI,
  input  logic       nIRQ,
  input  logic       processStatusRegIFlag,
  input  logic       nmiRunning,
  input  logic       instructionBoundary,
  output logic       synchronizedNMI,
  output logic       nmiGenerated,
  output logic       interruptAcknowleged,
  output logic       injectInterrupt,
  output logic       serviceIsNMI,
  output logic [2:0] sequenceStep,
  output logic [7:0] vectorAddrLow
);

  localparam logic [2:0] c_LAST_STEP = 3'(INJECT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_nmiSync;
  logic [SYNC_STAGES-1:0] r_irqSync;
  logic [SYNC_STAGES-1:0] r_nmiValid;
  logic                   r_nmiPrev;
  logic                   r_nmiArmed;
  logic                   r_nmiGenerated;
  logic                   r_serviceIsNMI;
  logic [2:0]             r_step;
  state_t                 r_state;

  logic w_nmiSyncN;
  logic w_irqSyncN;
  logic w_nmiEdge;
  logic w_nmiReq;
  logic w_irqReq;
  logic w_ack;

  assign w_nmiSyncN = r_nmiSync[SYNC_STAGES-1];
  assign w_irqSyncN = r_irqSync[SYNC_STAGES-1];

  // Only a fall from a genuinely sampled high counts; the reset value of the
  // chain is not evidence that the pin was ever high.
  assign w_nmiEdge = r_nmiArmed & r_nmiPrev & ~w_nmiSyncN;

  assign w_nmiReq = r_nmiGenerated & ~nmiRunning;
  assign w_irqReq = ~w_irqSyncN & ~processStatusRegIFlag;
  assign w_ack    = (r_state == IDLE) & enableFFs & instructionBoundary & (w_nmiReq | w_irqReq);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_nmiSync  <= '1;
      r_irqSync  <= '1;
      r_nmiValid <= '0;
      r_nmiPrev  <= 1'b1;
      r_nmiArmed <= 1'b0;
    end else begin
      r_nmiSync  <= {r_nmiSync[SYNC_STAGES-2:0], nNMI};
      r_irqSync  <= {r_irqSync[SYNC_STAGES-2:0], nIRQ};
      r_nmiValid <= {r_nmiValid[SYNC_STAGES-2:0], 1'b1};
      r_nmiPrev  <= w_nmiSyncN;
      r_nmiArmed <= r_nmiArmed | (r_nmiValid[SYNC_STAGES-1] & w_nmiSyncN);
    end
  end

  // A new edge arriving on the same clock as the grant keeps the request alive.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_nmiGenerated <= 1'b0;
    end else begin
      r_nmiGenerated <= w_nmiEdge | (r_nmiGenerated & ~(w_ack & w_nmiReq));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= IDLE;
      r_step         <= 3'd0;
      r_serviceIsNMI <= 1'b0;
    end else if (enableFFs) begin
      case (r_state)
        IDLE: begin
          if (w_ack) begin
            r_state        <= SEQ;
            r_step         <= 3'd0;
            r_serviceIsNMI <= w_nmiReq;
          end
        end
        SEQ: begin
          if (r_step == c_LAST_STEP) begin
            r_state <= IDLE;
            r_step  <= 3'd0;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_step  <= 3'd0;
        end
      endcase
    end
  end

  assign synchronizedNMI      = ~w_nmiSyncN;
  assign nmiGenerated         = r_nmiGenerated;
  assign interruptAcknowleged = w_ack;
  assign injectInterrupt      = (r_state == SEQ);
  assign serviceIsNMI         = r_serviceIsNMI;
  assign sequenceStep         = r_step;
  assign vectorAddrLow        = r_serviceIsNMI ? NMI_VECTOR_LO : IRQ_VECTOR_LO;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_injector.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_interrupt_injector: directed + random stimulus against a reference model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_interrupt_injector;

  localparam int SYNC_STAGES   = 2;
  localparam int INJECT_CYCLES = 7;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       enableFFs = 1'b1;
  logic       nNMI = 1'b0;
  logic       nIRQ = 1'b1;
  logic       iFlag = 1'b1;
  logic       nmiRunning = 1'b0;
  logic       boundary = 1'b0;
  logic       synchronizedNMI;
  logic       nmiGenerated;
  logic       interruptAcknowleged;
  logic       injectInterrupt;
  logic       serviceIsNMI;
  logic [2:0] sequenceStep;
  logic [7:0] vectorAddrLow;

  interrupt_injector #(
    .SYNC_STAGES  (SYNC_STAGES),
    .INJECT_CYCLES(INJECT_CYCLES),
    .NMI_VECTOR_LO(8'hFA),
    .IRQ_VECTOR_LO(8'hFE)
  ) dut (
    .clk                  (clk),
    .nrst                 (nrst),
    .enableFFs            (enableFFs),
    .nNMI                 (nNMI),
    .nIRQ                 (nIRQ),
    .processStatusRegIFlag(iFlag),
    .nmiRunning           (nmiRunning),
    .instructionBoundary  (boundary),
    .synchronizedNMI      (synchronizedNMI),
    .nmiGenerated         (nmiGenerated),
    .interruptAcknowleged (interruptAcknowleged),
    .injectInterrupt      (injectInterrupt),
    .serviceIsNMI         (serviceIsNMI),
    .sequenceStep         (sequenceStep),
    .vectorAddrLow        (vectorAddrLow)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: pin histories hold 0/1 samples, 2 marks a pre-sample reset filler.
  int mNmiHist[$];
  int mIrqHist[$];
  bit mPrevRealHigh;
  bit mNmiGen;
  bit mIsNmi;
  int mRemain;   // cycles of the injected sequence still to run, 0 = idle

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mNmiHist = {};
    mIrqHist = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      mNmiHist.push_back(2);
      mIrqHist.push_back(2);
    end
    mPrevRealHigh = 1'b0;
    mNmiGen       = 1'b0;
    mIsNmi        = 1'b0;
    mRemain       = 0;
  endtask

  function automatic bit mNmiReq();
    return mNmiGen && !nmiRunning;
  endfunction

  function automatic bit mIrqReq();
    return (mIrqHist[0] == 0) && !iFlag;
  endfunction

  function automatic bit mAck();
    return (mRemain == 0) && enableFFs && boundary && (mNmiReq() || mIrqReq());
  endfunction

  task automatic checkAll();
    chk1("syncNMI", synchronizedNMI, mNmiHist[0] == 0);
    chk1("nmiGenerated", nmiGenerated, mNmiGen);
    chk1("ack", interruptAcknowleged, mAck());
    chk1("inject", injectInterrupt, mRemain > 0);
    chk1("serviceIsNMI", serviceIsNMI, mIsNmi);
    chk8("step", {5'd0, sequenceStep}, (mRemain > 0) ? 8'(INJECT_CYCLES - mRemain) : 8'd0);
    chk8("vector", vectorAddrLow, mIsNmi ? 8'hFA : 8'hFE);
  endtask

  // Entered at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic cycle();
    bit ack;
    bit nReq;
    bit edgeNow;
    #1;
    checkAll();
    nReq    = mNmiReq();
    ack     = mAck();
    edgeNow = mPrevRealHigh && (mNmiHist[0] == 0);
    @(posedge clk);
    mPrevRealHigh = (mNmiHist[0] == 1);
    mNmiHist.push_back(int'(nNMI));
    void'(mNmiHist.pop_front());
    mIrqHist.push_back(int'(nIRQ));
    void'(mIrqHist.pop_front());
    if (edgeNow)           mNmiGen = 1'b1;
    else if (ack && nReq)  mNmiGen = 1'b0;
    if (enableFFs) begin
      if (mRemain == 0) begin
        if (ack) begin
          mRemain = INJECT_CYCLES;
          mIsNmi  = nReq;
        end
      end else begin
        mRemain--;
      end
    end
    #1;
  endtask

  task automatic applyReset();
    nrst = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    int n;
    int acks;
    modelReset();
    // Reset with the NMI pin already low.
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    chk8("rst_vector", vectorAddrLow, 8'hFE);
    nrst = 1'b1;

    // 1: low pin at release is not an edge; high-then-low is, after SYNC_STAGES+1 clocks.
    repeat (8) cycle();
    chk1("t1_noEdgeAtRelease", nmiGenerated, 1'b0);
    nNMI = 1'b1;
    repeat (4) cycle();
    nNMI = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!nmiGenerated && n < 10);
    chk8("t1_latency", 8'(n), 8'(SYNC_STAGES + 1));

    // 2: NMI grant and full sequence.
    boundary = 1'b1;
    #1;
    chk1("t2_ack", interruptAcknowleged, 1'b1);
    cycle();
    boundary = 1'b0;
    chk1("t2_nmiCleared", nmiGenerated, 1'b0);
    chk1("t2_isNmi", serviceIsNMI, 1'b1);
    chk8("t2_vector", vectorAddrLow, 8'hFA);
    for (int i = 0; i < INJECT_CYCLES; i++) begin
      chk8("t2_stepSeq", {5'd0, sequenceStep}, 8'(i));
      cycle();
    end
    chk1("t2_done", injectInterrupt, 1'b0);

    // 3: unmasked IRQ is granted; masked IRQ is not.
    nIRQ = 1'b0; iFlag = 1'b0; boundary = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!injectInterrupt && n < 10);
    chk1("t3_granted", injectInterrupt, 1'b1);
    chk8("t3_vector", vectorAddrLow, 8'hFE);
    nIRQ = 1'b1;
    repeat (INJECT_CYCLES) cycle();
    chk1("t3_done", injectInterrupt, 1'b0);
    nIRQ = 1'b0; iFlag = 1'b1;
    acks = 0;
    repeat (20) begin
      #1;
      if (interruptAcknowleged) acks++;
      cycle();
    end
    chk8("t3_maskedAcks", 8'(acks), 8'd0);

    // 4: NMI and IRQ pending together: NMI first, IRQ after the sequence.
    boundary = 1'b0; iFlag = 1'b0; nNMI = 1'b1;
    repeat (4) cycle();
    nNMI = 1'b0;
    repeat (4) cycle();
    boundary = 1'b1;
    cycle();
    chk1("t4_nmiFirst", serviceIsNMI, 1'b1);
    n = 0;
    do begin cycle(); n++; end while (!interruptAcknowleged && n < 20);
    chk8("t4_irqDelay", 8'(n), 8'(INJECT_CYCLES));
    cycle();
    chk1("t4_irqSecond", serviceIsNMI, 1'b0);
    nIRQ = 1'b1; boundary = 1'b0;
    repeat (8) cycle();

    // 5: step advances only on enabled clocks; NMI edge during stall is latched.
    nIRQ = 1'b0; boundary = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!injectInterrupt && n < 10);
    nIRQ = 1'b1; boundary = 1'b0;
    enableFFs = 1'b0;
    n = 0;
    while (injectInterrupt && n < 40) begin
      if (n == 2) nNMI = 1'b1;
      if (n == 7) nNMI = 1'b0;
      cycle();
      n++;
      enableFFs = ~enableFFs;
    end
    enableFFs = 1'b1;
    chk8("t5_seqLen", 8'(n), 8'(2 * INJECT_CYCLES));
    chk1("t5_nmiLatched", nmiGenerated, 1'b1);

    // 6: nmiRunning blocks the grant; reset mid-sequence aborts.
    nmiRunning = 1'b1; boundary = 1'b1;
    repeat (5) cycle();
    chk1("t6_blocked", injectInterrupt, 1'b0);
    nmiRunning = 1'b0;
    cycle();
    chk1("t6_granted", serviceIsNMI & injectInterrupt, 1'b1);
    boundary = 1'b0;
    repeat (3) cycle();
    chk8("t6_step3", {5'd0, sequenceStep}, 8'd3);
    applyReset();
    chk1("t6_rstInject", injectInterrupt, 1'b0);

    // Random traffic against the model.
    repeat (1500) begin
      if ($urandom_range(7) == 0)  nNMI = ~nNMI;
      if ($urandom_range(9) == 0)  nIRQ = ~nIRQ;
      if ($urandom_range(5) == 0)  iFlag = ~iFlag;
      if ($urandom_range(11) == 0) nmiRunning = ~nmiRunning;
      boundary  = ($urandom_range(2) == 0);
      enableFFs = ($urandom_range(4) != 0);
      if ($urandom_range(299) == 0) applyReset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
